fbcpu_boot_ctrl: RTL
====================

FBCPU_BOOT_CTRL -- requirements
Module: fbcpu_boot_ctrl

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH, default 6, RAM address width; DATA_WIDTH, default 10, RAM word width.
REQ-002 Ports SHALL be, in order:
clk  in  1  sole clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
start_load  in  1  request to begin a program load.
ld_len  in  ADDRESS_WIDTH+1  number of words to load (1..64); 0 SHALL be treated as 64.
max_cycles  in  16  RUN cycle budget; 0 = unlimited.
abort  in  1  stop the current LOAD or RUN.
ld_valid  in  1  loader word valid.
ld_data  in  DATA_WIDTH  loader word.
ld_ready  out  1  controller accepts a loader word.
cpu_MAR  in  ADDRESS_WIDTH  CPU address.
cpu_RAMWr  in  1  CPU write enable.
cpu_MDRIn  in  DATA_WIDTH  CPU write data.
cpu_rst  out  1  reset to the CPU core.
ram_addr  out  ADDRESS_WIDTH  muxed RAM address.
ram_we  out  1  muxed RAM write enable.
ram_wdata  out  DATA_WIDTH  muxed RAM write data.
state  out  2  current FSM state.
run_cycles  out  16  cycles spent in the current or last RUN.
done  out  1  in HALT.
timeout  out  1  last RUN ended on budget exhaustion.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE=0, LOAD=1, RUN=2, HALT=3, and state SHALL equal the registered state.
REQ-004 IDLE: cpu_rst=1, ld_ready=0, ram_we=0, ram_addr=0, ram_wdata=0; on start_load, go to LOAD, clear the load address counter, and latch ld_len.
REQ-005 LOAD: cpu_rst=1, ld_ready=1; a transfer is ld_valid&&ld_ready in the same cycle; on transfer, ram_addr=counter, ram_we=1, ram_wdata=ld_data combinationally in that cycle, and the counter increments; with no transfer, ram_we=0.
REQ-006 The transfer whose counter equals latched length-1 SHALL be the last one, and the FSM SHALL enter RUN on the next edge with run_cycles cleared to 0.
REQ-007 RUN: cpu_rst=0, ld_ready=0; ram_addr/ram_we/ram_wdata SHALL pass cpu_MAR/cpu_RAMWr/cpu_MDRIn through combinationally; run_cycles SHALL increment by 1 every RUN cycle and saturate at 0xFFFF.
REQ-008 In RUN with max_cycles!=0, when run_cycles==max_cycles-1, the next state SHALL be HALT with timeout set to 1, so RUN lasts exactly max_cycles cycles.
REQ-009 abort in LOAD or RUN SHALL force HALT on the next edge; a same-cycle final load transfer SHALL still write its word.
REQ-010 If abort and budget exhaustion coincide, the FSM SHALL go to HALT with timeout=1.
REQ-011 HALT: cpu_rst=1, ld_ready=0, ram_we=0, done=1; run_cycles and timeout SHALL hold; start_load SHALL enter LOAD (as in REQ-004) and clear timeout.
REQ-012 start_load SHALL be ignored in LOAD and RUN; abort SHALL be ignored in IDLE and HALT.
REQ-013 The RAM write address SHALL never exceed 2**ADDRESS_WIDTH-1; a length of 64 SHALL fill addresses 0..63 with no wrap.

Reset
REQ-014 rst, in any state including mid-LOAD or mid-RUN, SHALL on the next edge give: state=IDLE, cpu_rst=1, ld_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, run_cycles=0, done=0, timeout=0, load counter=0, latched length=0.
REQ-015 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-016 The state encoding constants and default widths (ADDRESS_WIDTH=6, DATA_WIDTH=10, cycle-counter width 16) SHALL live in the shared package fbcpu_pkg.
REQ-017 The saturating RUN cycle counter with its budget compare SHALL be one sub-module, fbcpu_run_timer; the RAM mux and FSM SHALL stay in fbcpu_boot_ctrl.

Verification
REQ-018 Load with ld_len=3, data 0x040,0x281,0x180, ld_valid held high: RAM addresses 0..2 written in 3 consecutive cycles, RUN entered on the 4th edge, cpu_rst falls to 0.
REQ-019 Load with ld_valid toggling 1,0,1,0,1 and ld_len=3: exactly 3 writes occur, none in ld_valid=0 cycles, and the addresses are 0,1,2.
REQ-020 max_cycles=5: RUN lasts exactly 5 cycles, then HALT with done=1, timeout=1, run_cycles=5 held; with max_cycles=0 and 70000 cycles, run_cycles=0xFFFF and the FSM stays in RUN.
REQ-021 ld_len=0 loads 64 words to addresses 0..63, and address 63 is followed by RUN with no write to address 0.
REQ-022 rst asserted mid-LOAD (after 2 of 5 words) and mid-RUN: next edge state=IDLE, cpu_rst=1, ram_we=0, all counters 0.
REQ-023 abort coincident with budget exhaustion leads to HALT with timeout=1; abort coincident with the final load word writes that word and enters HALT, not RUN.

Source files
------------

// File: rtl/fbcpu_pkg.sv
// Shared constants for the FBCPU boot controller: default widths and FSM state encoding.
package fbcpu_pkg;

  localparam int ADDRESS_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF    = 10;
  localparam int CYC_W             = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fbcpu_run_timer.sv
// Saturating RUN cycle counter with budget compare; expire is combinational from the
// registered count, so it flags the final budgeted cycle in the same cycle.
module fbcpu_run_timer
  import fbcpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CYC_W-1:0] max_cycles,
  output logic [CYC_W-1:0] run_cycles,
  output logic             expire
);

  localparam logic [CYC_W-1:0] ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  logic [CYC_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ONE;
    end
  end

  // A zero budget means run forever.
  assign expire     = en && (max_cycles != '0) && (cnt_q == (max_cycles - ONE));
  assign run_cycles = cnt_q;

endmodule

// File: rtl/fbcpu_boot_ctrl.sv
// Boot controller: loads a program into CPU RAM from a valid/ready stream, then releases the CPU.
// RAM port is a combinational mux (loader in LOAD, CPU in RUN); ld_ready is high only in LOAD.
module fbcpu_boot_ctrl
  import fbcpu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_load,
  input  logic [ADDRESS_WIDTH:0]   ld_len,
  input  logic [CYC_W-1:0]         max_cycles,
  input  logic                     abort,
  input  logic                     ld_valid,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_ready,
  input  logic [ADDRESS_WIDTH-1:0] cpu_MAR,
  input  logic                     cpu_RAMWr,
  input  logic [DATA_WIDTH-1:0]    cpu_MDRIn,
  output logic                     cpu_rst,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_we,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  output logic [1:0]               state,
  output logic [CYC_W-1:0]         run_cycles,
  output logic                     done,
  output logic                     timeout
);

  localparam int LW = ADDRESS_WIDTH + 1;
  localparam logic [LW-1:0] FULL_LEN = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [LW-1:0] LEN_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  fsm_state_t               st_q, st_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q;
  logic [LW-1:0]            len_q;
  logic [LW-1:0]            len_eff;
  logic                     timeout_q;
  logic                     xfer, last, start_ok;
  logic                     run_en, run_clr, expire;

  // Zero (and anything past the RAM size) means a full RAM, so the address never wraps.
  assign len_eff  = ((ld_len == '0) || (ld_len > FULL_LEN)) ? FULL_LEN : ld_len;
  assign xfer     = (st_q == ST_LOAD) && ld_valid;
  assign last     = xfer && ({1'b0, cnt_q} == (len_q - LEN_ONE));
  assign start_ok = start_load && ((st_q == ST_IDLE) || (st_q == ST_HALT));
  assign run_en   = (st_q == ST_RUN);

  always_comb begin
    st_d      = st_q;
    run_clr   = 1'b0;
    ld_ready  = 1'b0;
    cpu_rst   = 1'b1;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (st_q)
      ST_IDLE: begin
        if (start_load) st_d = ST_LOAD;
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        if (xfer) begin
          ram_we    = 1'b1;
          ram_addr  = cnt_q;
          ram_wdata = ld_data;
        end
        // Abort wins over completion, but the final word is still written above.
        if (abort) begin
          st_d = ST_HALT;
        end else if (last) begin
          st_d    = ST_RUN;
          run_clr = 1'b1;
        end
      end
      ST_RUN: begin
        cpu_rst   = 1'b0;
        ram_we    = cpu_RAMWr;
        ram_addr  = cpu_MAR;
        ram_wdata = cpu_MDRIn;
        if (expire || abort) st_d = ST_HALT;
      end
      ST_HALT: begin
        if (start_load) st_d = ST_LOAD;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      st_q <= st_d;
      if (start_ok) begin
        cnt_q     <= '0;
        len_q     <= len_eff;
        timeout_q <= 1'b0;
      end else if (xfer) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (run_en && expire) timeout_q <= 1'b1;
    end
  end

  fbcpu_run_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (run_clr),
    .en         (run_en),
    .max_cycles (max_cycles),
    .run_cycles (run_cycles),
    .expire     (expire)
  );

  assign state   = st_q;
  assign done    = (st_q == ST_HALT);
  assign timeout = timeout_q;

endmodule
